key_debouncer: RTL and testbench



---
 rtl/key_debouncer_pkg.sv | 27 ++
 rtl/key_debounce_lane.sv | 127 ++++++++++++
 rtl/key_debouncer.sv | 36 +++
 tb/tb_key_debouncer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/key_debouncer_pkg.sv
// rtl/key_debouncer_pkg.sv - shared types and width helpers for the key debouncer
// Purpose: lane FSM state encoding and counter-width helpers derived from the
//          debounce and long-press cycle parameters.
// Ports:   none (package).
package key_debouncer_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } dbnc_state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_LONG_CYCLES     = 50000000;

    // Debounce counter only ever holds 0..DEBOUNCE_CYCLES-1.
    function automatic int dbnc_cnt_w(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

    // Hold counter must reach LONG_CYCLES itself so it can saturate there.
    function automatic int hold_cnt_w(input int cycles);
        return (cycles <= 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/key_debounce_lane.sv
// rtl/key_debounce_lane.sv - one pushbutton lane: synchroniser, debounce FSM, hold counter
// Purpose: conditions a single raw active-low key into a clean active-high level
//          with one-cycle press, release and long-press pulses.
// Ports:   i_clk, i_rst_n (async active-low), i_key (raw, active-low),
//          o_level (debounced, active-high), o_press, o_release, o_long (pulses).
module key_debounce_lane
    import key_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int DW = dbnc_cnt_w(DEBOUNCE_CYCLES);
    localparam int HW = hold_cnt_w(LONG_CYCLES);
    localparam logic [DW-1:0] DBNC_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

    logic          s1, s2;
    dbnc_state_e   state, state_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [HW-1:0] hcnt, hcnt_n, hold_inc;
    logic          held, press_n, release_n, long_n, level_n;

    // Reset to 1 so a lane never starts out looking pressed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= i_key;
            s2 <= s1;
        end
    end

    assign held     = (state == PRESSED) || (state == RELEASE_PEND);
    assign hold_inc = (held && hcnt != HOLD_MAX) ? hcnt + HW'(1) : hcnt;

    always_comb begin
        state_n   = state;
        dcnt_n    = dcnt;
        hcnt_n    = hcnt;
        press_n   = 1'b0;
        release_n = 1'b0;
        case (state)
            RELEASED: begin
                if (!s2) begin
                    state_n = PRESS_PEND;
                    dcnt_n  = DW'(1);
                end
            end
            PRESS_PEND: begin
                if (s2) begin
                    state_n = RELEASED;
                    dcnt_n  = '0;
                end else if (dcnt == DBNC_LAST) begin
                    state_n = PRESSED;
                    press_n = 1'b1;
                    dcnt_n  = '0;
                    hcnt_n  = '0;
                end else begin
                    dcnt_n = dcnt + DW'(1);
                end
            end
            PRESSED: begin
                hcnt_n = hold_inc;
                if (s2) begin
                    state_n = RELEASE_PEND;
                    dcnt_n  = DW'(1);
                end
            end
            RELEASE_PEND: begin
                if (!s2) begin
                    state_n = PRESSED;
                    dcnt_n  = '0;
                    hcnt_n  = hold_inc;
                end else if (dcnt == DBNC_LAST) begin
                    state_n   = RELEASED;
                    release_n = 1'b1;
                    dcnt_n    = '0;
                    hcnt_n    = '0;
                end else begin
                    dcnt_n = dcnt + DW'(1);
                    hcnt_n = hold_inc;
                end
            end
            default: begin
                state_n = RELEASED;
                dcnt_n  = '0;
                hcnt_n  = '0;
            end
        endcase
    end

    // Long pulse only on the transition into saturation; an accepted release
    // clears the hold count first, so it always wins over a coinciding long.
    assign long_n  = held && !release_n && (hcnt_n == HOLD_MAX) && (hcnt != HOLD_MAX);
    assign level_n = (state_n == PRESSED) || (state_n == RELEASE_PEND);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= RELEASED;
            dcnt      <= '0;
            hcnt      <= '0;
            o_level   <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_long    <= 1'b0;
        end else begin
            state     <= state_n;
            dcnt      <= dcnt_n;
            hcnt      <= hcnt_n;
            o_level   <= level_n;
            o_press   <= press_n;
            o_release <= release_n;
            o_long    <= long_n;
        end
    end

endmodule

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - multi-key pushbutton conditioner, one independent lane per key
// Purpose: conditions NUM_KEYS raw active-low pushbuttons for downstream logic.
// Ports:   i_clk, i_rst_n (async active-low), i_key[NUM_KEYS] (raw, active-low),
//          o_level/o_press/o_release/o_long[NUM_KEYS] (per-lane outputs).
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NUM_KEYS-1:0] i_key,
    output logic [NUM_KEYS-1:0] o_level,
    output logic [NUM_KEYS-1:0] o_press,
    output logic [NUM_KEYS-1:0] o_release,
    output logic [NUM_KEYS-1:0] o_long
);

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_lane
        key_debounce_lane #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_lane (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_key     (i_key[g]),
            .o_level   (o_level[g]),
            .o_press   (o_press[g]),
            .o_release (o_release[g]),
            .o_long    (o_long[g])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// tb/tb_key_debouncer.sv - self-checking scoreboard bench for key_debouncer
module tb_key_debouncer;

    localparam int D  = 8;
    localparam int L  = 20;
    localparam int NK = 4;
    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_LONG  = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] key   = '1;
    logic [NK-1:0] o_level, o_press, o_release, o_long;

    key_debouncer #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_key     (key),
        .o_level   (o_level),
        .o_press   (o_press),
        .o_release (o_release),
        .o_long    (o_long)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;
    int exp_q[$];

    // Event code: cycle, lane and pulse kind packed into one integer.
    function automatic int ev(input int c, input int lane, input int kind);
        return c * 16 + lane * 4 + kind;
    endfunction

    function automatic logic pulse_bit(input int lane, input int kind);
        if (kind == K_PRESS) return o_press[lane];
        if (kind == K_REL)   return o_release[lane];
        return o_long[lane];
    endfunction

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Every observed pulse must be the next expected event, at the right cycle.
    always @(negedge clk) begin
        for (int ln = 0; ln < NK; ln++) begin
            for (int k = 0; k < 3; k++) begin
                if (pulse_bit(ln, k)) begin
                    if (exp_q.size() == 0) check_eq("unexpected_pulse", ev(cyc, ln, k), -1);
                    else                   check_eq("pulse_event", ev(cyc, ln, k), exp_q.pop_front());
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    int c, r;

    initial begin
        // Reset with every key held down
        key = '0;
        wait_cyc(3);
        check_eq("rst_level",   o_level,   0);
        check_eq("rst_press",   o_press,   0);
        check_eq("rst_release", o_release, 0);
        check_eq("rst_long",    o_long,    0);
        c = cyc;
        rst_n = 1'b1;
        for (int ln = 0; ln < NK; ln++) exp_q.push_back(ev(c + D + 2, ln, K_PRESS));
        wait_cyc(D + 1);
        check_eq("rst_held_level_pre", o_level, 0);
        wait_cyc(1);
        check_eq("rst_held_level", o_level, 4'hF);
        key = '1;
        for (int ln = 0; ln < NK; ln++) exp_q.push_back(ev(c + 2 * D + 4, ln, K_REL));
        wait_cyc(D + 4);
        check_eq("rst_released_level", o_level, 0);

        // Clean press on key 0
        c = cyc;
        key[0] = 1'b0;
        exp_q.push_back(ev(c + D + 2, 0, K_PRESS));
        wait_cyc(D + 1);
        check_eq("clean_level_pre", o_level, 0);
        wait_cyc(1);
        check_eq("clean_level", o_level, 4'b0001);
        wait_cyc(1);
        check_eq("clean_press_1cyc", o_press, 0);
        key[0] = 1'b1;
        exp_q.push_back(ev(c + 2 * D + 5, 0, K_REL));
        wait_cyc(D + 4);

        // Bounce on key 1
        key[1] = 1'b0; wait_cyc(5);
        key[1] = 1'b1; wait_cyc(2);
        key[1] = 1'b0; wait_cyc(5);
        key[1] = 1'b1; wait_cyc(3);
        check_eq("bounce_no_level", o_level, 0);
        c = cyc;
        key[1] = 1'b0;
        exp_q.push_back(ev(c + D + 2, 1, K_PRESS));
        wait_cyc(D + 1);
        check_eq("bounce_level_pre", o_level, 0);
        wait_cyc(1);
        check_eq("bounce_level", o_level, 4'b0010);
        key[1] = 1'b1;
        exp_q.push_back(ev(c + 2 * D + 4, 1, K_REL));
        wait_cyc(D + 4);

        // Long press on key 2
        c = cyc;
        key[2] = 1'b0;
        exp_q.push_back(ev(c + D + 2, 2, K_PRESS));
        exp_q.push_back(ev(c + D + 2 + L, 2, K_LONG));
        wait_cyc(40);
        check_eq("long_level", o_level, 4'b0100);
        key[2] = 1'b1;
        exp_q.push_back(ev(c + 40 + D + 2, 2, K_REL));
        wait_cyc(D + 4);

        // Release glitch of 7 cycles on key 3; hold count keeps running
        c = cyc;
        key[3] = 1'b0;
        exp_q.push_back(ev(c + D + 2, 3, K_PRESS));
        exp_q.push_back(ev(c + D + 2 + L, 3, K_LONG));
        wait_cyc(12);
        key[3] = 1'b1;
        wait_cyc(7);
        key[3] = 1'b0;
        wait_cyc(3);
        check_eq("glitch_level", o_level, 4'b1000);
        wait_cyc(13);
        check_eq("glitch_level_late", o_level, 4'b1000);
        key[3] = 1'b1;
        exp_q.push_back(ev(c + 35 + D + 2, 3, K_REL));
        wait_cyc(D + 4);

        // Release accepted on the very cycle the long pulse would fire
        c = cyc;
        key[0] = 1'b0;
        exp_q.push_back(ev(c + D + 2, 0, K_PRESS));
        wait_cyc(L);
        key[0] = 1'b1;
        exp_q.push_back(ev(c + L + D + 2, 0, K_REL));
        wait_cyc(D + 2);
        check_eq("race_long",    o_long,    0);
        check_eq("race_release", o_release, 4'b0001);
        wait_cyc(5);

        // Async reset while key 1 is mid-debounce and key 2 is pressed
        c = cyc;
        key[2] = 1'b0;
        exp_q.push_back(ev(c + D + 2, 2, K_PRESS));
        wait_cyc(12);
        key[1] = 1'b0;
        wait_cyc(6);
        check_eq("pre_reset_level", o_level, 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_level",   o_level,   0);
        check_eq("async_rst_release", o_release, 0);
        wait_cyc(2);
        rst_n = 1'b1;
        r = cyc;
        exp_q.push_back(ev(r + D + 2, 1, K_PRESS));
        exp_q.push_back(ev(r + D + 2, 2, K_PRESS));
        wait_cyc(D + 1);
        check_eq("post_rst_level_pre", o_level, 0);
        wait_cyc(1);
        check_eq("post_rst_level", o_level, 4'b0110);
        key = '1;
        exp_q.push_back(ev(r + 2 * D + 4, 1, K_REL));
        exp_q.push_back(ev(r + 2 * D + 4, 2, K_REL));
        wait_cyc(D + 6);

        check_eq("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
